// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with req/ready memory handshake, stall hold buffer and branch redirect drain
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_instr,
  output logic        IF_valid,
  output logic        misaligned
);
  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, drain_addr_q, drain_addr_d;
  logic [31:0] hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
  logic [31:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d, mis_q, mis_d;
  assign imem_req   = !reset && state_q != HOLD;
  assign imem_addr  = state_q == DRAIN ? drain_addr_q : pc_q;
  assign IF_PC      = if_pc_q;
  assign IF_instr   = if_instr_q;
  assign IF_valid   = if_valid_q;
  assign misaligned = mis_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;
    mis_d        = 1'b0;
    if (branch_taken) begin
      pc_d         = {branch_target[31:2], 2'b00};
      mis_d        = |branch_target[1:0];
      if_instr_d   = BUBBLE_INSTR;
      if_valid_d   = 1'b0;
      hold_pc_d    = '0;
      hold_instr_d = BUBBLE_INSTR;
      state_d      = (state_q != HOLD && !imem_ready) ? DRAIN : FETCH;
      // a second redirect while draining must keep the address already on the bus
      drain_addr_d = state_q == FETCH ? pc_q : drain_addr_q;
    end else if (state_q == HOLD) begin
      if (!stall) begin
        if_pc_d    = hold_pc_q;
        if_instr_d = hold_instr_q;
        if_valid_d = 1'b1;
        state_d    = FETCH;
      end
    end else if (state_q == DRAIN) begin
      state_d = imem_ready ? FETCH : DRAIN;
    end else if (imem_ready) begin
      pc_d = pc_q + 32'd4;
      if (stall) begin
        hold_pc_d    = pc_q;
        hold_instr_d = imem_rdata;
        state_d      = HOLD;
      end else begin
        if_pc_d    = pc_q;
        if_instr_d = imem_rdata;
        if_valid_d = 1'b1;
      end
    end else if (!stall) begin
      if_instr_d = BUBBLE_INSTR;
      if_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= BUBBLE_INSTR;
      if_pc_q      <= '0;
      if_instr_q   <= BUBBLE_INSTR;
      if_valid_q   <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_valid_q   <= if_valid_d;
      mis_q        <= mis_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and random stimulus against a flag-based reference model of the fetch stage
module tb_if_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] BUB = 32'h0000_0000;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, imem_req, imem_ready, IF_valid, misaligned;
  logic [31:0] branch_target, imem_addr, imem_rdata, IF_PC, IF_instr;
  int          n_chk = 0, n_err = 0;
  logic        m_buf = 1'b0, m_disc = 1'b0, m_valid = 1'b0, m_mis = 1'b0;
  logic [31:0] m_pc = RPC, m_old = RPC, m_hpc = '0, m_hins = '0, m_ifpc = '0, m_ifins = '0;

  if_fetch_stage #(.RESET_PC(RPC), .BUBBLE_INSTR(BUB)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .IF_PC(IF_PC),
    .IF_instr(IF_instr), .IF_valid(IF_valid), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} + 32'h100;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt, input logic rdy);
    logic        e_req;
    logic [31:0] e_addr;
    @(negedge clk);
    e_req         = !r && !m_buf;
    e_addr        = m_disc ? m_old : m_pc;
    reset         = r;
    stall         = s;
    branch_taken  = b;
    branch_target = bt;
    imem_ready    = rdy && e_req;
    imem_rdata    = mem(e_addr);
    #1;
    check("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) check("imem_addr", imem_addr, e_addr);
    @(posedge clk);
    if (r) begin
      m_pc = RPC; m_buf = 0; m_disc = 0; m_ifpc = '0; m_ifins = BUB; m_valid = 0; m_mis = 0;
    end else if (b) begin
      m_mis = bt[1:0] != 2'b00;
      m_ifins = BUB; m_valid = 0;
      if (!m_buf && !imem_ready) begin
        if (!m_disc) m_old = m_pc;
        m_disc = 1;
      end else m_disc = 0;
      m_buf = 0;
      m_pc = bt & ~32'd3;
    end else begin
      m_mis = 0;
      if (m_buf) begin
        if (!s) begin m_ifpc = m_hpc; m_ifins = m_hins; m_valid = 1; m_buf = 0; end
      end else if (m_disc) begin
        if (imem_ready) m_disc = 0;
      end else if (imem_ready) begin
        if (s) begin m_buf = 1; m_hpc = m_pc; m_hins = imem_rdata; end
        else begin m_ifpc = m_pc; m_ifins = imem_rdata; m_valid = 1; end
        m_pc = m_pc + 32'd4;
      end else if (!s) begin
        m_ifins = BUB; m_valid = 0;
      end
    end
    #1;
    check("IF_PC", IF_PC, m_ifpc);
    check("IF_instr", IF_instr, m_ifins);
    check("IF_valid", 32'(IF_valid), 32'(m_valid));
    check("misaligned", 32'(misaligned), 32'(m_mis));
  endtask

  initial begin
    logic [31:0] bt;
    repeat (2) step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    repeat (3) begin step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 1); end
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h40, 0);
    step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 1, 1, 32'h22, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h80, 0);
    step(0, 0, 1, 32'h90, 0);
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'hFFFF_FFF8, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    repeat (3000) begin
      bt = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           bt, $urandom_range(0, 1) == 1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
